if_scratch_loader: RTL and testbench
====================================

// Module: if_scratch_loader
// PURPOSE
//  Streams one input-feature row at a time into the IF scratchpad, which it treats as a circular buffer.
//  Tells the downstream PE/address generator when a full filter window is resident.
//  Retires consumed elements by a programmable stride.
//  Flushes the row tail when the row ends, then accepts the next row.
// PARAMETERS
//  ADDR_LEN       4   scratch address width
//  SCRATCH_DEPTH  16  scratch entries; 2**ADDR_LEN >= SCRATCH_DEPTH
//  SCRATCH_WIDTH  8   element width
//  FILT_SIZE      4   window length in elements; 1..SCRATCH_DEPTH
// PORTS
//  clk        in   1          clock, single domain
//  rst        in   1          synchronous, active-low reset
//  stride     in   ADDR_LEN   window advance; sampled on a row's first accepted element; 0 treated as 1
//  in_valid   in   1          upstream element valid
//  in_ready   out  1          loader can accept an element
//  in_data    in   SCRATCH_WIDTH  element
//  in_last    in   1          qualifies the final element of a row
//  sc_wen     out  1          scratch write enable
//  sc_waddr   out  ADDR_LEN   scratch write address
//  sc_din     out  SCRATCH_WIDTH  scratch write data
//  win_valid  out  1          FILT_SIZE elements from win_base are resident
//  win_base   out  ADDR_LEN   address of the window's first element
//  win_done   in   1          consumer finished the current window
//  row_end    out  1          1-cycle pulse when a row is fully retired
//  occupancy  out  ADDR_LEN+1 resident element count
//  win_count  out  16         windows retired (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE; wp=rb=occupancy=0; outputs in_ready=1, win_valid=0, row_end=0, win_count=0.
//  Write path:
//   - in_ready = (state in {IDLE,FILL}) && occupancy < SCRATCH_DEPTH.
//   - Accept = in_valid & in_ready. sc_wen=accept, sc_waddr=wp, sc_din=in_data; all combinational.
//   - wp += 1 on accept, wrapping SCRATCH_DEPTH-1 -> 0.
//  Pointer arithmetic: every wp/rb sum wraps modulo SCRATCH_DEPTH (if sum >= DEPTH then subtract DEPTH).
//  occupancy is registered. win_valid = (occupancy >= FILT_SIZE) && state in {FILL,DRAIN}.
//  Latency: win_valid rises the cycle after the FILT_SIZE-th accept, so the scratch write has already landed.
//  win_base = rb.
//  Retire: win_done && win_valid -> adv = min(stride_q, occupancy); rb += adv; occupancy -= adv; win_count += 1.
//   - win_done while win_valid==0 is ignored.
//  Simultaneous accept and retire: occupancy_next = occupancy + 1 - adv.
//  FSM:
//   - IDLE : occupancy==0. First accept -> latch stride_q -> FILL. If that element also has in_last -> DRAIN.
//   - FILL : accept elements; serve windows. Accept with in_last -> DRAIN.
//   - DRAIN: no accepts; serve windows. When occupancy_next < FILT_SIZE -> FLUSH.
//   - FLUSH: one cycle. rb += occupancy; occupancy = 0; row_end = 1; next state IDLE.
//  Boundary cases:
//   - Row shorter than FILT_SIZE: no window; DRAIN -> FLUSH the next cycle.
//   - Full (occupancy==DEPTH): in_ready=0 until a retire. No element is ever overwritten.
//   - stride > FILT_SIZE: elements are skipped; adv is capped at occupancy.
//   - Reset mid-row: all state is discarded; scratch contents are don't-care.
// CONFIGURATION
//  IF_LOADER_STATS_EN defined:
//   - win_count counts retired windows, saturating at 16'hFFFF.
//   - win_count is cleared by reset only.
//  IF_LOADER_STATS_EN undefined:
//   - win_count is tied to 0 and the counter is not built.
//   - All other behaviour is identical.
// TESTING
//  1. Basic row: stride=1, row of 6 elems 10..15, win_done held high.
//     -> win_base 0,1,2; row_end 1 cycle after the 3rd retire; occupancy returns to 0; rb=6.
//  2. Stride 2, row of 8: -> win_base 0,2,4; then FLUSH retires 2 elems; win_count=3 (STATS_EN).
//  3. Short row: 3 elems with in_last on the 3rd -> win_valid never rises; row_end pulses 2 cycles after the last accept.
//  4. Backpressure: 16 elems, no win_done.
//     -> in_ready=0 with occupancy=16; one win_done(stride=1) -> in_ready=1 next cycle; next write to addr 0 (wrap).
//  5. Simultaneous accept + win_done at occupancy=5, stride=1 -> occupancy stays 5; wp and rb both +1.
//  6. rst=0 asserted in FILL with occupancy=7 -> next cycle occupancy=0, win_valid=0, in_ready=1; next row writes addr 0.

Source files
------------

// File: rtl/if_scratch_loader.sv
// -----------------------------------------------------------------------------
// if_scratch_loader
//
// Streams one input-feature row at a time into the IF scratchpad. The
// scratchpad is used as a circular buffer. A write pointer (wp) tracks where
// the next element lands. A retire base (rb) marks the oldest resident
// element. The loader raises win_valid while a full filter window of
// FILT_SIZE elements is resident starting at win_base. The consumer answers
// with win_done. Each retire drops min(stride, occupancy) elements. Once the
// row's last element has arrived and no further window fits, the leftover
// tail is flushed, row_end pulses, and the loader accepts the next row.
//
// Optional feature (compile-time macro IF_LOADER_STATS_EN):
//   defined   -> win_count counts retired windows, saturating at 16'hFFFF,
//                and is cleared only by reset.
//   undefined -> win_count is tied to zero and no counter is built.
//
// Ports
//   clk        clock, single domain
//   rst        synchronous, active-low reset
//   stride     window advance, sampled on a row's first accepted element
//              (0 behaves as 1)
//   in_valid   upstream element valid
//   in_ready   loader can accept an element
//   in_data    element data
//   in_last    marks the final element of a row
//   sc_wen     scratch write enable
//   sc_waddr   scratch write address
//   sc_din     scratch write data
//   win_valid  FILT_SIZE elements starting at win_base are resident
//   win_base   address of the window's first element
//   win_done   consumer finished the current window
//   row_end    one-cycle pulse when a row has been fully retired
//   occupancy  resident element count
//   win_count  retired-window count (zero unless IF_LOADER_STATS_EN is defined)
// -----------------------------------------------------------------------------
module if_scratch_loader #(
  parameter int ADDR_LEN      = 4,
  parameter int SCRATCH_DEPTH = 16,
  parameter int SCRATCH_WIDTH = 8,
  parameter int FILT_SIZE     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_LEN-1:0]      stride,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SCRATCH_WIDTH-1:0] in_data,
  input  logic                     in_last,
  output logic                     sc_wen,
  output logic [ADDR_LEN-1:0]      sc_waddr,
  output logic [SCRATCH_WIDTH-1:0] sc_din,
  output logic                     win_valid,
  output logic [ADDR_LEN-1:0]      win_base,
  input  logic                     win_done,
  output logic                     row_end,
  output logic [ADDR_LEN:0]        occupancy,
  output logic [15:0]              win_count
);

  localparam int OCC_W = ADDR_LEN + 1;
  localparam logic [OCC_W-1:0] DEPTH_O = OCC_W'(SCRATCH_DEPTH);
  localparam logic [OCC_W-1:0] FILT_O  = OCC_W'(FILT_SIZE);
  localparam logic [OCC_W:0]   DEPTH_S = (OCC_W + 1)'(SCRATCH_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [ADDR_LEN-1:0] wp_reg, wp_next;
  logic [ADDR_LEN-1:0] rb_reg, rb_next;
  logic [ADDR_LEN-1:0] stride_reg, stride_next;
  logic [OCC_W-1:0]    occ_reg, occ_next;

  logic             accept;
  logic             retire;
  logic [OCC_W-1:0] adv;

  // Circular-buffer add. base < DEPTH and inc <= DEPTH, so the sum is below
  // 2*DEPTH. One conditional subtraction therefore wraps it back into range.
  function automatic logic [ADDR_LEN-1:0] wrap_add(
    input logic [ADDR_LEN-1:0] base,
    input logic [OCC_W-1:0]    inc
  );
    logic [OCC_W:0] sum;
    sum = {2'b00, base} + {1'b0, inc};
    if (sum >= DEPTH_S) begin
      sum = sum - DEPTH_S;
    end
    return ADDR_LEN'(sum);
  endfunction

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = in_last ? DRAIN : FILL;
        end
      end
      FILL: begin
        if (accept && in_last) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        // This looks at the post-retire count. The flush therefore follows
        // directly on the cycle that retires the last complete window.
        if (occ_next < FILT_O) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    win_valid = 1'b0;
    row_end   = 1'b0;
    unique case (state_reg)
      IDLE: begin
        in_ready = (occ_reg < DEPTH_O);
      end
      FILL: begin
        in_ready  = (occ_reg < DEPTH_O);
        win_valid = (occ_reg >= FILT_O);
      end
      DRAIN: begin
        win_valid = (occ_reg >= FILT_O);
      end
      FLUSH: begin
        row_end = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write path and retire handshake
  // ---------------------------------------------------------------------------
  assign accept   = in_valid & in_ready;
  assign retire   = win_done & win_valid;
  // A stride longer than what is resident skips elements. The advance is
  // capped at occupancy so that rb never passes wp.
  assign adv      = ({1'b0, stride_reg} < occ_reg) ? {1'b0, stride_reg} : occ_reg;

  assign sc_wen    = accept;
  assign sc_waddr  = wp_reg;
  assign sc_din    = in_data;
  assign win_base  = rb_reg;
  assign occupancy = occ_reg;

  always_comb begin
    wp_next     = wp_reg;
    rb_next     = rb_reg;
    occ_next    = occ_reg;
    stride_next = stride_reg;

    if (accept) begin
      wp_next = wrap_add(wp_reg, OCC_W'(1));
    end

    // The stride is captured once per row, on the row's first element.
    if ((state_reg == IDLE) && accept) begin
      stride_next = (stride == '0) ? ADDR_LEN'(1) : stride;
    end

    if (state_reg == FLUSH) begin
      // Discard the tail that cannot form a full window.
      rb_next  = wrap_add(rb_reg, occ_reg);
      occ_next = '0;
    end else begin
      if (retire) begin
        rb_next = wrap_add(rb_reg, adv);
      end
      occ_next = occ_reg + OCC_W'(accept) - (retire ? adv : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wp_reg     <= '0;
      rb_reg     <= '0;
      occ_reg    <= '0;
      stride_reg <= ADDR_LEN'(1);
    end else begin
      wp_reg     <= wp_next;
      rb_reg     <= rb_next;
      occ_reg    <= occ_next;
      stride_reg <= stride_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional retired-window statistics
  // ---------------------------------------------------------------------------
`ifdef IF_LOADER_STATS_EN
  logic [15:0] win_count_reg, win_count_next;

  always_comb begin
    win_count_next = win_count_reg;
    if (retire && (win_count_reg != 16'hFFFF)) begin
      win_count_next = win_count_reg + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      win_count_reg <= '0;
    end else begin
      win_count_reg <= win_count_next;
    end
  end

  assign win_count = win_count_reg;
`else
  assign win_count = '0;
`endif

endmodule

// File: tb/tb_if_scratch_loader.sv
module tb_if_scratch_loader;

`ifdef IF_LOADER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] stride;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       sc_wen;
  logic [3:0] sc_waddr;
  logic [7:0] sc_din;
  logic       win_valid;
  logic [3:0] win_base;
  logic       win_done;
  logic       row_end;
  logic [4:0] occupancy;
  logic [15:0] win_count;

  int vectors     = 0;
  int miscompares = 0;

  // Scoreboards: expected writes {addr,data} and expected window bases.
  logic [11:0] wq[$];
  logic [3:0]  rq[$];
  logic [3:0]  wp_m;

  if_scratch_loader dut (
    .clk       (clk),
    .rst       (rst),
    .stride    (stride),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .sc_wen    (sc_wen),
    .sc_waddr  (sc_waddr),
    .sc_din    (sc_din),
    .win_valid (win_valid),
    .win_base  (win_base),
    .win_done  (win_done),
    .row_end   (row_end),
    .occupancy (occupancy),
    .win_count (win_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  // One clock cycle. Observes the scoreboarded events at the falling edge, then
  // returns just after the next rising edge.
  task automatic tick();
    logic [11:0] w;
    logic [3:0]  b;
    @(negedge clk);
    if (sc_wen) begin
      vectors++;
      if (wq.size() == 0) begin
        miscompares++;
        $display("FAIL write_unexpected: got addr=%0d data=%0h, required no write", sc_waddr, sc_din);
      end else begin
        w = wq.pop_front();
        if ({sc_waddr, sc_din} !== w) begin
          miscompares++;
          $display("FAIL write: got addr=%0d data=%0h, required addr=%0d data=%0h",
                   sc_waddr, sc_din, w[11:8], w[7:0]);
        end else begin
          $display("write  addr=%0d data=%0h", sc_waddr, sc_din);
        end
      end
    end
    if (win_valid && win_done) begin
      vectors++;
      if (rq.size() == 0) begin
        miscompares++;
        $display("FAIL retire_unexpected: got win_base=%0d, required no retire", win_base);
      end else begin
        b = rq.pop_front();
        if (win_base !== b) begin
          miscompares++;
          $display("FAIL retire: got win_base=%0d, required %0d", win_base, b);
        end else begin
          $display("retire win_base=%0d occupancy=%0d", win_base, occupancy);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_elem(input logic [7:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    wq.push_back({wp_m, d});
    wp_m = wp_m + 4'd1;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic apply_reset();
    rst      = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    win_done = 1'b0;
    tick();
    tick();
    rst  = 1'b1;
    wp_m = 4'd0;
    wq.delete();
    rq.delete();
  endtask

  task automatic test_reset();
    rst      = 1'b0;
    stride   = 4'd1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    win_done = 1'b0;
    wp_m     = 4'd0;
    repeat (3) tick();
    rst = 1'b1;
    vectors++;
    if (in_ready !== 1'b1 || win_valid !== 1'b0 || row_end !== 1'b0 || occupancy !== 5'd0 ||
        win_count !== 16'd0 || win_base !== 4'd0 || sc_wen !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: got rdy=%b wv=%b re=%b occ=%0d wc=%0d wb=%0d wen=%b, required 1 0 0 0 0 0 0",
               in_ready, win_valid, row_end, occupancy, win_count, win_base, sc_wen);
    end else $display("reset  ok");
  endtask

  task automatic test_basic();
    apply_reset();
    stride   = 4'd1;
    win_done = 1'b1;
    rq.push_back(4'd0); rq.push_back(4'd1); rq.push_back(4'd2);
    for (int i = 0; i < 6; i++) drive_elem(8'(10 + i), i == 5);
    vectors++;
    if (row_end !== 1'b0 || win_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_drain: got row_end=%b win_valid=%b, required 0 1", row_end, win_valid);
    end
    tick();
    vectors++;
    if (row_end !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_row_end: got row_end=%b, required 1", row_end);
    end
    tick();
    win_done = 1'b0;
    vectors++;
    if (occupancy !== 5'd0 || win_base !== 4'd6 || row_end !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_after: got occ=%0d rb=%0d row_end=%b rdy=%b, required 0 6 0 1",
               occupancy, win_base, row_end, in_ready);
    end
    vectors++;
    if (win_count !== (STATS ? 16'd3 : 16'd0)) begin
      miscompares++;
      $display("FAIL basic_win_count: got %0d, required %0d", win_count, STATS ? 3 : 0);
    end
    vectors++;
    if (wq.size() != 0 || rq.size() != 0) begin
      miscompares++;
      $display("FAIL basic_pending: got writes=%0d windows=%0d outstanding, required 0 0", wq.size(), rq.size());
    end
  endtask

  task automatic test_stride2();
    apply_reset();
    stride   = 4'd2;
    win_done = 1'b1;
    rq.push_back(4'd0); rq.push_back(4'd2); rq.push_back(4'd4);
    for (int i = 0; i < 8; i++) drive_elem(8'(8'h20 + i), i == 7);
    tick();
    vectors++;
    if (row_end !== 1'b1 || occupancy !== 5'd2) begin
      miscompares++;
      $display("FAIL s2_flush: got row_end=%b occ=%0d, required 1 2", row_end, occupancy);
    end
    tick();
    win_done = 1'b0;
    vectors++;
    if (occupancy !== 5'd0 || win_base !== 4'd8) begin
      miscompares++;
      $display("FAIL s2_after: got occ=%0d rb=%0d, required 0 8", occupancy, win_base);
    end
    vectors++;
    if (win_count !== (STATS ? 16'd3 : 16'd0)) begin
      miscompares++;
      $display("FAIL s2_win_count: got %0d, required %0d", win_count, STATS ? 3 : 0);
    end
    vectors++;
    if (wq.size() != 0 || rq.size() != 0) begin
      miscompares++;
      $display("FAIL s2_pending: got writes=%0d windows=%0d outstanding, required 0 0", wq.size(), rq.size());
    end
  endtask

  task automatic test_short_row();
    apply_reset();
    stride   = 4'd1;
    win_done = 1'b1;
    for (int i = 0; i < 3; i++) drive_elem(8'(8'h30 + i), i == 2);
    vectors++;
    if (row_end !== 1'b0 || win_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL short_drain: got row_end=%b win_valid=%b, required 0 0", row_end, win_valid);
    end
    tick();
    vectors++;
    if (row_end !== 1'b1 || win_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL short_row_end: got row_end=%b win_valid=%b, required 1 0", row_end, win_valid);
    end
    tick();
    win_done = 1'b0;
    vectors++;
    if (row_end !== 1'b0 || occupancy !== 5'd0 || win_base !== 4'd3 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL short_after: got row_end=%b occ=%0d rb=%0d rdy=%b, required 0 0 3 1",
               row_end, occupancy, win_base, in_ready);
    end
    vectors++;
    if (wq.size() != 0) begin
      miscompares++;
      $display("FAIL short_pending: got writes=%0d outstanding, required 0", wq.size());
    end
  endtask

  task automatic test_stride_edge();
    apply_reset();
    // Stride 7 exceeds the window. The advance caps at occupancy. The live
    // stride changes after the first element and must be ignored.
    win_done = 1'b1;
    stride   = 4'd7;
    rq.push_back(4'd0);
    for (int i = 0; i < 6; i++) begin
      drive_elem(8'(8'h40 + i), i == 5);
      stride = 4'd1;
    end
    tick();
    vectors++;
    if (row_end !== 1'b1 || occupancy !== 5'd2) begin
      miscompares++;
      $display("FAIL s7_flush: got row_end=%b occ=%0d, required 1 2", row_end, occupancy);
    end
    tick();
    vectors++;
    if (win_base !== 4'd6 || occupancy !== 5'd0) begin
      miscompares++;
      $display("FAIL s7_after: got rb=%0d occ=%0d, required 6 0", win_base, occupancy);
    end
    // A stride of 0 behaves as 1. A later live value of 3 must not leak in.
    stride = 4'd0;
    rq.push_back(4'd6); rq.push_back(4'd7);
    for (int i = 0; i < 5; i++) begin
      drive_elem(8'(8'h50 + i), i == 4);
      stride = 4'd3;
    end
    tick();
    vectors++;
    if (row_end !== 1'b1 || occupancy !== 5'd3) begin
      miscompares++;
      $display("FAIL s0_flush: got row_end=%b occ=%0d, required 1 3", row_end, occupancy);
    end
    tick();
    win_done = 1'b0;
    vectors++;
    if (win_base !== 4'd11 || occupancy !== 5'd0) begin
      miscompares++;
      $display("FAIL s0_after: got rb=%0d occ=%0d, required 11 0", win_base, occupancy);
    end
    vectors++;
    if (wq.size() != 0 || rq.size() != 0) begin
      miscompares++;
      $display("FAIL stride_pending: got writes=%0d windows=%0d outstanding, required 0 0", wq.size(), rq.size());
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    stride   = 4'd1;
    win_done = 1'b0;
    for (int i = 0; i < 16; i++) drive_elem(8'(8'h60 + i), 1'b0);
    vectors++;
    if (in_ready !== 1'b0 || occupancy !== 5'd16 || win_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_full: got rdy=%b occ=%0d wv=%b, required 0 16 1", in_ready, occupancy, win_valid);
    end
    // Offered but not accepted; the element is absent from the scoreboard.
    in_valid = 1'b1;
    in_data  = 8'hEE;
    tick();
    in_valid = 1'b0;
    vectors++;
    if (in_ready !== 1'b0 || occupancy !== 5'd16) begin
      miscompares++;
      $display("FAIL bp_hold: got rdy=%b occ=%0d, required 0 16", in_ready, occupancy);
    end
    win_done = 1'b1;
    rq.push_back(4'd0);
    tick();
    win_done = 1'b0;
    vectors++;
    if (in_ready !== 1'b1 || occupancy !== 5'd15 || win_base !== 4'd1) begin
      miscompares++;
      $display("FAIL bp_release: got rdy=%b occ=%0d rb=%0d, required 1 15 1", in_ready, occupancy, win_base);
    end
    drive_elem(8'h55, 1'b0);
    vectors++;
    if (occupancy !== 5'd16 || wq.size() != 0 || rq.size() != 0) begin
      miscompares++;
      $display("FAIL bp_wrap: got occ=%0d pending writes=%0d windows=%0d, required 16 0 0",
               occupancy, wq.size(), rq.size());
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    stride   = 4'd1;
    win_done = 1'b0;
    for (int i = 0; i < 5; i++) drive_elem(8'(8'h70 + i), 1'b0);
    vectors++;
    if (occupancy !== 5'd5 || win_base !== 4'd0) begin
      miscompares++;
      $display("FAIL sim_pre: got occ=%0d rb=%0d, required 5 0", occupancy, win_base);
    end
    win_done = 1'b1;
    rq.push_back(4'd0);
    drive_elem(8'h75, 1'b0);
    win_done = 1'b0;
    vectors++;
    if (occupancy !== 5'd5 || win_base !== 4'd1) begin
      miscompares++;
      $display("FAIL sim_both: got occ=%0d rb=%0d, required 5 1", occupancy, win_base);
    end
    drive_elem(8'h76, 1'b0);
    vectors++;
    if (occupancy !== 5'd6 || wq.size() != 0 || rq.size() != 0) begin
      miscompares++;
      $display("FAIL sim_next: got occ=%0d pending writes=%0d windows=%0d, required 6 0 0",
               occupancy, wq.size(), rq.size());
    end
  endtask

  task automatic test_reset_mid_row();
    apply_reset();
    stride   = 4'd1;
    win_done = 1'b0;
    for (int i = 0; i < 7; i++) drive_elem(8'(8'h80 + i), 1'b0);
    vectors++;
    if (occupancy !== 5'd7 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_pre: got occ=%0d rdy=%b, required 7 1", occupancy, in_ready);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    vectors++;
    if (occupancy !== 5'd0 || win_valid !== 1'b0 || in_ready !== 1'b1 || win_base !== 4'd0 ||
        row_end !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: got occ=%0d wv=%b rdy=%b rb=%0d re=%b, required 0 0 1 0 0",
               occupancy, win_valid, in_ready, win_base, row_end);
    end
    wp_m = 4'd0;
    wq.delete();
    drive_elem(8'h99, 1'b0);
    vectors++;
    if (occupancy !== 5'd1 || wq.size() != 0) begin
      miscompares++;
      $display("FAIL mid_restart: got occ=%0d pending writes=%0d, required 1 0", occupancy, wq.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stride2();
    test_short_row();
    test_stride_edge();
    test_backpressure();
    test_simultaneous();
    test_reset_mid_row();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
